uart8_receiver: RTL and testbench
=================================

Name: uart8_receiver

Overview:
- 8-bit UART receiver, 8N1 framing: one start bit, 8 data bits LSB first, one stop bit. Counterpart of the 8-bit transmitter.
- Receive clock runs at OVERSAMPLE × baud. Each bit is sampled once at its midpoint.
- Delivers each received byte on a parallel bus with a one-cycle done strobe. Sits between the pad (rx line) and the host byte sink.

Parameters:
- OVERSAMPLE, 16, receive clocks per bit period; even, ≥4.
- CNT_W, 4, sample counter width; must satisfy 2^CNT_W ≥ OVERSAMPLE.

Ports:
- clk  in  1  receive clock, OVERSAMPLE × baud.
- rst  in  1  synchronous, active-high reset.
- en  in  1  RX enable; sampled only in IDLE.
- in  in  1  asynchronous RX line, idle high.
- out  out  8  last good received byte.
- done  out  1  one-cycle strobe: out just updated.
- busy  out  1  high while a frame is in progress (any state other than IDLE).
- err  out  1  one-cycle strobe: framing error (stop bit sampled low).
- perr  out  1  one-cycle parity error strobe; tied 0 when the parity option is absent.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out=8'h00, done=0, busy=0, err=0, perr=0. Sample counter, bit index and shift register cleared. Sync flops set to 1. Reset mid-frame aborts the frame with no strobe.
- Input synchronizer: `in` always passes through a 2-flop synchronizer, giving rx_s. A prev flop gives rx_p. Fall edge = rx_p & ~rx_s.
- done, err, perr default to 0 every cycle. Each is high for exactly one cycle.
- IDLE: busy=0. On fall edge & en, go to START_BIT with cnt=0. A held-low line (e.g. after a framing error) produces no new edge, so no restart until the line goes high then low again.
- START_BIT:
  - cnt counts up. At cnt == OVERSAMPLE/2-1 (mid start bit), check rx_s.
  - rx_s==0: go to DATA_BITS with cnt=0, bitIdx=0.
  - rx_s==1: false start; return to IDLE with no strobe.
- DATA_BITS:
  - At cnt == OVERSAMPLE-1: data[bitIdx] <= rx_s, cnt=0.
  - If bitIdx==7, go to STOP_BIT (or PARITY_BIT when the parity option is on); otherwise bitIdx+1.
- STOP_BIT: at cnt == OVERSAMPLE-1, sample rx_s.
  - rx_s==1: out <= data and done=1.
  - rx_s==0: err=1 and out is unchanged.
  - Either way, go to IDLE the next cycle.
- en: deasserting en mid-frame does not abort the frame.
- Latency: done/err rises (OVERSAMPLE/2) + 9·OVERSAMPLE + 1 clocks after the first cycle rx_s is low, plus 2 synchronizer clocks from the pin.
- Back-to-back frames: the return to IDLE happens at mid stop bit, so a start edge arriving half a bit later is caught.
- State encoding: codes RESET, IDLE, START_BIT, DATA_BITS, STOP_BIT, PARITY_BIT come from the shared state header. Any undefined code goes to IDLE on the next clock.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds PARITY_BIT state, an even-parity bit after data bit 7.
  - Sampled at mid-bit and compared with ^data.
  - On mismatch, perr=1 in the same cycle as done or err. Out is still updated if the stop bit is good.
  - Latency grows by OVERSAMPLE.
- Undefined: no PARITY_BIT state, perr tied 0, 8N1 only.

Decomposition:
- Shared state header: existing state codes plus PARITY_BIT, so TX and RX share encoding.
- Sub-module uart_rx_sync: 2-flop synchronizer plus fall-edge detector. Reset value 1. Reusable for other async inputs.

Test Plan (OVERSAMPLE=16):
- Clean frame 0x55 at 16 clk/bit, en=1:
  - done pulses once, out=8'h55, err=0.
  - done lands 153 clocks after the first low rx_s, per the latency formula.
- Glitch: in low for 4 clocks, then high → no done/err, busy returns to 0, state IDLE.
- Framing error: frame 0xA3 with stop bit 0 → err pulses, done=0, out keeps its previous value. No new frame starts until `in` goes high then low.
- Back-to-back frames 0xA3 then 0x3C, with no idle gap → two done pulses, out=8'hA3 then 8'h3C.
- Reset mid-frame: rst=1 during data bit 4 → all outputs 0 next cycle, no strobe. The next full frame 0x0F is received correctly.
- en=0 during a start edge → frame ignored, busy stays 0.
- With UART_RX_PARITY_EN:
  - 0x07 with parity 1 → done, perr=0.
  - 0x07 with parity 0 → done and perr together, out=8'h07.

Source files
------------

// File: rtl/uart8_receiver_pkg.sv
// Shared UART state encoding (common to TX and RX) and small helpers.
// PARITY_BIT is only reached when UART_RX_PARITY_EN is defined.
package uart8_receiver_pkg;

    typedef enum logic [2:0] {
        RESET      = 3'd0,
        IDLE       = 3'd1,
        START_BIT  = 3'd2,
        DATA_BITS  = 3'd3,
        STOP_BIT   = 3'd4,
        PARITY_BIT = 3'd5
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart8_receiver_sync.sv
// uart_rx_sync: 2-flop synchronizer plus falling-edge detector for an async input.
// All flops reset to 1 (idle-high line), so no edge is seen coming out of reset.
module uart_rx_sync
    import uart8_receiver_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign q    = sync_r;
    assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver, one mid-bit sample per bit at OVERSAMPLE clocks per bit.
// Define UART_RX_PARITY_EN to add an even-parity bit after data bit 7 (drives perr).
module uart8_receiver
    import uart8_receiver_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 32'd16,
    parameter int unsigned CNT_W      = 32'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       done,
    output logic       busy,
    output logic       err,
    output logic       perr
);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 32'd2 - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 32'd1);

    uart_state_e      state_r;
    uart_state_e      state_nx;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       out_r;
    logic             done_r;
    logic             err_r;
    logic             perr_r;
    logic             busy_r;
    logic             rx_s;
    logic             fall_s;
    logic             done_nx;
    logic             err_nx;
    logic             perr_nx;
    logic             stop_smp_s;
`ifdef UART_RX_PARITY_EN
    logic             pmis_r;
`endif

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (in),
        .q    (rx_s),
        .fall (fall_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; unknown codes (including RESET) fall back to IDLE
    always_comb begin
        state_nx = IDLE;
        case (state_r)
            IDLE: begin
                if (fall_s && en) state_nx = START_BIT;
                else              state_nx = IDLE;
            end
            START_BIT: begin
                if (cnt_r == CNT_MID) begin
                    if (rx_s) state_nx = IDLE;
                    else      state_nx = DATA_BITS;
                end else begin
                    state_nx = START_BIT;
                end
            end
            DATA_BITS: begin
                if ((cnt_r == CNT_LAST) && (bit_idx_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = PARITY_BIT;
`else
                    state_nx = STOP_BIT;
`endif
                end else begin
                    state_nx = DATA_BITS;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
                if (cnt_r == CNT_LAST) state_nx = STOP_BIT;
                else                   state_nx = PARITY_BIT;
            end
`endif
            STOP_BIT: begin
                if (cnt_r == CNT_LAST) state_nx = IDLE;
                else                   state_nx = STOP_BIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobe decode at the stop-bit sample point
    always_comb begin
        stop_smp_s = (state_r == STOP_BIT) && (cnt_r == CNT_LAST);
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        perr_nx    = 1'b0;
        if (stop_smp_s) begin
            done_nx = rx_s;
            err_nx  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_nx = pmis_r;
`else
            perr_nx = 1'b0;
`endif
        end else begin
            done_nx = 1'b0;
            err_nx  = 1'b0;
            perr_nx = 1'b0;
        end
    end

    // Datapath: sample counter, bit shifter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            out_r     <= 8'h00;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            perr_r    <= 1'b0;
            busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pmis_r    <= 1'b0;
`endif
        end else begin
            done_r <= done_nx;
            err_r  <= err_nx;
            perr_r <= perr_nx;
            busy_r <= (state_nx != IDLE);
            if (done_nx) out_r <= shift_r;
            case (state_r)
                START_BIT: begin
                    if (cnt_r == CNT_MID) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r              <= '0;
                        shift_r[bit_idx_r] <= rx_s;
                        bit_idx_r          <= bit_idx_r + 3'd1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY_BIT: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r  <= '0;
                        pmis_r <= rx_s ^ even_parity(shift_r);
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
`endif
                STOP_BIT: begin
                    if (cnt_r == CNT_LAST) cnt_r <= '0;
                    else                   cnt_r <= cnt_r + 1'b1;
                end
                default: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

    assign out  = out_r;
    assign done = done_r;
    assign err  = err_r;
    assign perr = perr_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed bench for uart8_receiver at OVERSAMPLE=16; strobes are tallied by a
// negedge monitor and compared against hand-computed counts and bytes.
module tb_uart8_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       in;
    logic [7:0] out;
    logic       done;
    logic       busy;
    logic       err;
    logic       perr;

    int checks;
    int errors;
    int cyc;
    int done_cnt;
    int err_cnt;
    int perr_cnt;
    int busy_cyc;
    int last_done_cyc;
    int frame_start_cyc;
    int d0;
    int e0;
    int p0;
    int b0;

    uart8_receiver #(.OVERSAMPLE(16), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .in   (in),
        .out  (out),
        .done (done),
        .busy (busy),
        .err  (err),
        .perr (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (err)  err_cnt  <= err_cnt + 1;
        if (perr) perr_cnt <= perr_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        in = b;
        repeat (16) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        done_cnt = 0; err_cnt = 0; perr_cnt = 0; busy_cyc = 0; last_done_cyc = 0;
        rst = 1'b1; en = 1'b1; in = 1'b1;
        repeat (3) tick();
        check("rst_out",  {24'd0, out}, 32'h00);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err",  {31'd0, err}, 32'd0);
        check("rst_perr", {31'd0, perr}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // Clean 0x55 frame
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        check("clean_done_cnt", done_cnt - d0, 32'd1);
        check("clean_out", {24'd0, out}, 32'h55);
        check("clean_err_cnt", err_cnt - e0, 32'd0);
        check("clean_latency", last_done_cyc - frame_start_cyc, LAT);
        check("clean_busy_idle", {31'd0, busy}, 32'd0);

        // Short glitch: false start
        d0 = done_cnt; e0 = err_cnt;
        in = 1'b0;
        repeat (4) tick();
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        in = 1'b1;
        repeat (20) tick();
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_done", done_cnt - d0, 32'd0);
        check("glitch_err", err_cnt - e0, 32'd0);

        // Framing error, then line stays low
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA3, 1'b0, 1'b0);
        check("ferr_err_cnt", err_cnt - e0, 32'd1);
        check("ferr_done_cnt", done_cnt - d0, 32'd0);
        check("ferr_out_kept", {24'd0, out}, 32'h55);
        b0 = busy_cyc; e0 = err_cnt;
        repeat (40) tick();
        check("ferr_low_busy", busy_cyc - b0, 32'd0);
        check("ferr_low_err", err_cnt - e0, 32'd0);
        in = 1'b1;
        repeat (16) tick();

        // Back-to-back frames
        d0 = done_cnt;
        send_frame(8'hA3, 1'b0, 1'b1);
        check("b2b_first_out", {24'd0, out}, 32'hA3);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("b2b_second_out", {24'd0, out}, 32'h3C);
        check("b2b_done_cnt", done_cnt - d0, 32'd2);
        repeat (8) tick();

        // Reset during data bit 4 of 0x5A (bit 4 is 1, line high)
        d0 = done_cnt; e0 = err_cnt;
        in = 1'b0; repeat (16) tick();
        in = 1'b0; repeat (16) tick();
        in = 1'b1; repeat (16) tick();
        in = 1'b0; repeat (16) tick();
        in = 1'b1; repeat (16) tick();
        in = 1'b1; repeat (8) tick();
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_out",  {24'd0, out}, 32'h00);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (40) tick();
        check("mrst_no_strobe", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        send_frame(8'h0F, 1'b0, 1'b1);
        check("post_rst_out", {24'd0, out}, 32'h0F);
        check("post_rst_done", done_cnt - d0, 32'd1);

        // Disabled receiver ignores a frame
        d0 = done_cnt; b0 = busy_cyc;
        en = 1'b0;
        send_frame(8'h99, 1'b0, 1'b1);
        check("en0_busy", busy_cyc - b0, 32'd0);
        check("en0_done", done_cnt - d0, 32'd0);
        check("en0_out", {24'd0, out}, 32'h0F);
        en = 1'b1;
        repeat (8) tick();

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_done", done_cnt - d0, 32'd1);
        check("par_ok_perr", perr_cnt - p0, 32'd0);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h70, 1'b1, 1'b1);
        check("par_ok2_out", {24'd0, out}, 32'h70);
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_bad_done", done_cnt - d0, 32'd2);
        check("par_bad_perr", perr_cnt - p0, 32'd1);
        check("par_bad_out", {24'd0, out}, 32'h07);
`else
        check("noparity_perr_cnt", perr_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
